// File: rtl/transition_collector_pkg.sv
// -----------------------------------------------------------------------------
// transition_collector_pkg
// Shared definitions for the DQN datapath blocks: FSM state encoding of the
// transition collector and the default parameter values.
// -----------------------------------------------------------------------------
package transition_collector_pkg;

  localparam int TC_DATA_WIDTH        = 32;
  localparam int TC_ACTION_WIDTH      = 2;
  localparam int TC_MAX_EPISODE_STEPS = 200;
  localparam int TC_COUNT_WIDTH       = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_INIT = 3'd1,
    ST_OBSERVE   = 3'd2,
    ST_WAIT_ACT  = 3'd3,
    ST_WAIT_ENV  = 3'd4,
    ST_EMIT      = 3'd5
  } tc_state_e;

endpackage : transition_collector_pkg

// File: rtl/transition_collector.sv
// -----------------------------------------------------------------------------
// transition_collector
// Drives one environment episode at a time and collects
// (state, action, reward, next state, done) tuples for replay memory.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_enable                   allows a new episode to start (sampled in IDLE)
//   i_env_valid/state/reward/done  environment observation
//   o_env_reset                one-cycle pulse: reset the environment
//   o_env_action_valid/action  one-cycle pulse: apply action to environment
//   o_obs_valid/o_obs_state    one-cycle pulse: current state to the agent
//   i_act_valid/i_action       agent's chosen action
//   o_valid + tuple outputs    one-cycle pulse: transition to replay memory
//   o_step_count               steps taken in the current episode
//   o_episode_count            completed episodes (wraps at 2^16)
// -----------------------------------------------------------------------------
module transition_collector
  import transition_collector_pkg::*;
#(
  parameter int DATA_WIDTH        = TC_DATA_WIDTH,
  parameter int ACTION_WIDTH      = TC_ACTION_WIDTH,
  parameter int MAX_EPISODE_STEPS = TC_MAX_EPISODE_STEPS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_enable,
  input  logic                    i_env_valid,
  input  logic [DATA_WIDTH-1:0]   i_env_state_0,
  input  logic [DATA_WIDTH-1:0]   i_env_state_1,
  input  logic [DATA_WIDTH-1:0]   i_env_reward,
  input  logic                    i_env_done,
  output logic                    o_env_reset,
  output logic                    o_env_action_valid,
  output logic [ACTION_WIDTH-1:0] o_env_action,
  output logic                    o_obs_valid,
  output logic [DATA_WIDTH-1:0]   o_obs_state_0,
  output logic [DATA_WIDTH-1:0]   o_obs_state_1,
  input  logic                    i_act_valid,
  input  logic [ACTION_WIDTH-1:0] i_action,
  output logic                    o_valid,
  output logic [DATA_WIDTH-1:0]   o_current_state_0,
  output logic [DATA_WIDTH-1:0]   o_current_state_1,
  output logic [ACTION_WIDTH-1:0] o_action,
  output logic [DATA_WIDTH-1:0]   o_reward,
  output logic [DATA_WIDTH-1:0]   o_next_state_0,
  output logic [DATA_WIDTH-1:0]   o_next_state_1,
  output logic                    o_done,
  output logic [15:0]             o_step_count,
  output logic [15:0]             o_episode_count
);

  localparam logic [15:0] MaxSteps = 16'(MAX_EPISODE_STEPS);

  tc_state_e state_q, state_d;

  // Current state seen by the agent and the action it picked for it.
  logic [DATA_WIDTH-1:0]   cur_0_q, cur_1_q;
  logic [ACTION_WIDTH-1:0] act_q;

  // Pulse registers.
  logic env_reset_q, env_act_valid_q, valid_q;

  // Tuple output registers: loaded once per step and held between pulses,
  // independent of cur_*_q which advances in EMIT.
  logic [DATA_WIDTH-1:0]   out_cur_0_q, out_cur_1_q;
  logic [ACTION_WIDTH-1:0] out_act_q;
  logic [DATA_WIDTH-1:0]   out_rew_q;
  logic [DATA_WIDTH-1:0]   out_nxt_0_q, out_nxt_1_q;
  logic                    out_done_q;

  logic [15:0] step_q, episode_q;
  logic [15:0] step_inc;

  // Handshake strobes, each only meaningful in its own state.
  logic start_fire, init_fire, act_fire, env_fire, emit_fire;

  always_comb begin
    start_fire = (state_q == ST_IDLE)      && i_enable;
    init_fire  = (state_q == ST_WAIT_INIT) && i_env_valid;
    act_fire   = (state_q == ST_WAIT_ACT)  && i_act_valid;
    env_fire   = (state_q == ST_WAIT_ENV)  && i_env_valid;
    emit_fire  = (state_q == ST_EMIT);
    step_inc   = step_q + 16'd1;
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (i_enable)    state_d = ST_WAIT_INIT;
      ST_WAIT_INIT: if (i_env_valid) state_d = ST_OBSERVE;
      ST_OBSERVE:                    state_d = ST_WAIT_ACT;
      ST_WAIT_ACT:  if (i_act_valid) state_d = ST_WAIT_ENV;
      ST_WAIT_ENV:  if (i_env_valid) state_d = ST_EMIT;
      ST_EMIT:      state_d = out_done_q ? ST_IDLE : ST_OBSERVE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_0_q         <= '0;
      cur_1_q         <= '0;
      act_q           <= '0;
      env_reset_q     <= 1'b0;
      env_act_valid_q <= 1'b0;
      valid_q         <= 1'b0;
      out_cur_0_q     <= '0;
      out_cur_1_q     <= '0;
      out_act_q       <= '0;
      out_rew_q       <= '0;
      out_nxt_0_q     <= '0;
      out_nxt_1_q     <= '0;
      out_done_q      <= 1'b0;
      step_q          <= '0;
      episode_q       <= '0;
    end else begin
      env_reset_q     <= start_fire;
      env_act_valid_q <= act_fire;
      // o_valid rises in the EMIT cycle, together with the freshly loaded tuple.
      valid_q         <= env_fire;

      if (init_fire) begin
        cur_0_q <= i_env_state_0;
        cur_1_q <= i_env_state_1;
      end

      if (act_fire) act_q <= i_action;

      if (env_fire) begin
        out_cur_0_q <= cur_0_q;
        out_cur_1_q <= cur_1_q;
        out_act_q   <= act_q;
        out_rew_q   <= i_env_reward;
        out_nxt_0_q <= i_env_state_0;
        out_nxt_1_q <= i_env_state_1;
        // Hitting the step limit truncates the episode as if the env ended it.
        out_done_q  <= i_env_done | (step_inc == MaxSteps);
        step_q      <= step_inc;
      end

      if (emit_fire) begin
        if (out_done_q) begin
          step_q    <= '0;
          episode_q <= episode_q + 16'd1;
        end else begin
          cur_0_q <= out_nxt_0_q;
          cur_1_q <= out_nxt_1_q;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    o_env_reset        = env_reset_q;
    o_env_action_valid = env_act_valid_q;
    o_env_action       = act_q;
    o_obs_valid        = (state_q == ST_OBSERVE);
    o_obs_state_0      = cur_0_q;
    o_obs_state_1      = cur_1_q;
    o_valid            = valid_q;
    o_current_state_0  = out_cur_0_q;
    o_current_state_1  = out_cur_1_q;
    o_action           = out_act_q;
    o_reward           = out_rew_q;
    o_next_state_0     = out_nxt_0_q;
    o_next_state_1     = out_nxt_1_q;
    o_done             = out_done_q;
    o_step_count       = step_q;
    o_episode_count    = episode_q;
  end

endmodule : transition_collector

// File: tb/tb_transition_collector.sv
// -----------------------------------------------------------------------------
// tb_transition_collector
// Scoreboard bench: expected tuples and observations are queued when the
// environment/agent stimulus is driven and compared when the DUT pulses
// o_valid / o_obs_valid.
// -----------------------------------------------------------------------------
module tb_transition_collector;

  localparam int DW  = 32;
  localparam int AW  = 2;
  localparam int MAX = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_enable = 1'b0;
  logic          i_env_valid = 1'b0;
  logic [DW-1:0] i_env_state_0 = '0, i_env_state_1 = '0, i_env_reward = '0;
  logic          i_env_done = 1'b0;
  logic          o_env_reset, o_env_action_valid;
  logic [AW-1:0] o_env_action;
  logic          o_obs_valid;
  logic [DW-1:0] o_obs_state_0, o_obs_state_1;
  logic          i_act_valid = 1'b0;
  logic [AW-1:0] i_action = '0;
  logic          o_valid;
  logic [DW-1:0] o_current_state_0, o_current_state_1, o_reward;
  logic [DW-1:0] o_next_state_0, o_next_state_1;
  logic [AW-1:0] o_action;
  logic          o_done;
  logic [15:0]   o_step_count, o_episode_count;

  always #5 clk = ~clk;

  transition_collector #(
    .DATA_WIDTH(DW), .ACTION_WIDTH(AW), .MAX_EPISODE_STEPS(MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable),
    .i_env_valid(i_env_valid), .i_env_state_0(i_env_state_0),
    .i_env_state_1(i_env_state_1), .i_env_reward(i_env_reward),
    .i_env_done(i_env_done),
    .o_env_reset(o_env_reset), .o_env_action_valid(o_env_action_valid),
    .o_env_action(o_env_action),
    .o_obs_valid(o_obs_valid), .o_obs_state_0(o_obs_state_0),
    .o_obs_state_1(o_obs_state_1),
    .i_act_valid(i_act_valid), .i_action(i_action),
    .o_valid(o_valid), .o_current_state_0(o_current_state_0),
    .o_current_state_1(o_current_state_1), .o_action(o_action),
    .o_reward(o_reward), .o_next_state_0(o_next_state_0),
    .o_next_state_1(o_next_state_1), .o_done(o_done),
    .o_step_count(o_step_count), .o_episode_count(o_episode_count)
  );

  typedef struct {
    logic [DW-1:0] c0, c1;
    logic [AW-1:0] a;
    logic [DW-1:0] r, n0, n1;
    logic          d;
  } tuple_t;

  typedef struct {
    logic [DW-1:0] s0, s1;
  } obs_t;

  tuple_t tuple_q[$];
  obs_t   obs_q[$];

  int total = 0;
  int bad   = 0;

  // Model state
  logic [DW-1:0] cur0_m, cur1_m;
  int            step_m = 0;
  int            ep_m   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Tuple scoreboard
  always @(negedge clk) begin
    if (o_valid) begin
      if (tuple_q.size() == 0) begin
        check("unexpected_o_valid", {63'd0, o_valid}, 64'd0);
      end else begin
        tuple_t e;
        e = tuple_q.pop_front();
        $display("tuple cur=(%0d,%0d) act=%0d rew=%0d next=(%0d,%0d) done=%0d",
                 o_current_state_0, o_current_state_1, o_action, o_reward,
                 o_next_state_0, o_next_state_1, o_done);
        check("tuple_cur0", 64'(o_current_state_0), 64'(e.c0));
        check("tuple_cur1", 64'(o_current_state_1), 64'(e.c1));
        check("tuple_act",  64'(o_action),          64'(e.a));
        check("tuple_rew",  64'(o_reward),          64'(e.r));
        check("tuple_nxt0", 64'(o_next_state_0),    64'(e.n0));
        check("tuple_nxt1", 64'(o_next_state_1),    64'(e.n1));
        check("tuple_done", 64'(o_done),            64'(e.d));
      end
    end
  end

  // Observation scoreboard
  always @(negedge clk) begin
    if (o_obs_valid) begin
      if (obs_q.size() == 0) begin
        check("unexpected_obs_valid", {63'd0, o_obs_valid}, 64'd0);
      end else begin
        obs_t e;
        e = obs_q.pop_front();
        $display("obs state=(%0d,%0d)", o_obs_state_0, o_obs_state_1);
        check("obs_s0", 64'(o_obs_state_0), 64'(e.s0));
        check("obs_s1", 64'(o_obs_state_1), 64'(e.s1));
      end
    end
  end

  // Called at a negedge while the DUT is in IDLE.
  task automatic start_episode(input logic [DW-1:0] s0, input logic [DW-1:0] s1);
    obs_t o;
    @(posedge clk); #1 i_enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("env_reset_pulse", 64'(o_env_reset), 64'd1);
    i_enable = 1'b0;
    @(negedge clk);
    check("env_reset_once", 64'(o_env_reset), 64'd0);
    cur0_m = s0; cur1_m = s1;
    o.s0 = s0; o.s1 = s1;
    obs_q.push_back(o);
    @(posedge clk); #1;
    i_env_valid = 1'b1; i_env_state_0 = s0; i_env_state_1 = s1;
    i_env_reward = 32'hFFFF; i_env_done = 1'b1;   // ignored while waiting for init
    @(posedge clk); #1;
    i_env_valid = 1'b0; i_env_done = 1'b0;
    @(negedge clk);
    check("obs_valid_after_init", 64'(o_obs_valid), 64'd1);
  endtask

  // Called at the negedge of the o_obs_valid cycle.
  task automatic do_act(input logic [AW-1:0] a, input bit spurious);
    if (spurious) begin
      @(posedge clk); #1;
      i_env_valid = 1'b1; i_env_state_0 = 32'hDEAD; i_env_state_1 = 32'hBEEF;
      i_env_reward = 32'h55; i_env_done = 1'b1;
      @(posedge clk); #1;
      i_env_valid = 1'b0; i_env_done = 1'b0;
      @(negedge clk);
      check("spur_env_no_valid", 64'(o_valid), 64'd0);
      check("spur_env_no_act",   64'(o_env_action_valid), 64'd0);
      check("spur_env_obs_hold", 64'(o_obs_state_0), 64'(cur0_m));
    end
    @(posedge clk); #1 i_act_valid = 1'b1; i_action = a;
    @(posedge clk); #1 i_act_valid = 1'b0;
    @(negedge clk);
    check("env_action_valid", 64'(o_env_action_valid), 64'd1);
    check("env_action_code",  64'(o_env_action), 64'(a));
    if (spurious) begin
      @(posedge clk); #1 i_act_valid = 1'b1; i_action = ~a;
      @(posedge clk); #1 i_act_valid = 1'b0;
      @(negedge clk);
      check("spur_act_no_pulse", 64'(o_env_action_valid), 64'd0);
      check("spur_act_hold",     64'(o_env_action), 64'(a));
      check("spur_act_no_valid", 64'(o_valid), 64'd0);
    end
  endtask

  // Called while the DUT waits for the environment response.
  task automatic do_env(input logic [AW-1:0] a, input logic [DW-1:0] n0, input logic [DW-1:0] n1,
                        input logic [DW-1:0] r, input bit d_in);
    tuple_t t;
    obs_t   o;
    bit     d;
    step_m++;
    d = d_in || (step_m == MAX);
    t.c0 = cur0_m; t.c1 = cur1_m; t.a = a; t.r = r; t.n0 = n0; t.n1 = n1; t.d = d;
    tuple_q.push_back(t);
    if (!d) begin
      o.s0 = n0; o.s1 = n1;
      obs_q.push_back(o);
    end
    @(posedge clk); #1;
    i_env_valid = 1'b1; i_env_state_0 = n0; i_env_state_1 = n1;
    i_env_reward = r; i_env_done = d_in;
    @(posedge clk); #1;
    i_env_valid = 1'b0; i_env_done = 1'b0;
    @(negedge clk);
    check("valid_latency", 64'(o_valid), 64'd1);
    check("step_count_emit", 64'(o_step_count), 64'(step_m));
    @(negedge clk);
    check("valid_one_cycle", 64'(o_valid), 64'd0);
    check("obs_latency", 64'(o_obs_valid), 64'(!d));
    check("reward_hold", 64'(o_reward), 64'(r));
    if (d) begin
      step_m = 0;
      ep_m++;
    end else begin
      cur0_m = n0; cur1_m = n1;
    end
    check("step_count", 64'(o_step_count), 64'(step_m));
    check("episode_count", 64'(o_episode_count), 64'(ep_m));
  endtask

  task automatic do_step(input logic [AW-1:0] a, input logic [DW-1:0] n0, input logic [DW-1:0] n1,
                         input logic [DW-1:0] r, input bit d_in, input bit spurious);
    do_act(a, spurious);
    do_env(a, n0, n1, r, d_in);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_env_reset"}, 64'(o_env_reset), 64'd0);
    check({tag, "_obs_valid"}, 64'(o_obs_valid), 64'd0);
    check({tag, "_valid"},     64'(o_valid), 64'd0);
    check({tag, "_env_act"},   64'(o_env_action), 64'd0);
    check({tag, "_obs_s0"},    64'(o_obs_state_0), 64'd0);
    check({tag, "_cur0"},      64'(o_current_state_0), 64'd0);
    check({tag, "_reward"},    64'(o_reward), 64'd0);
    check({tag, "_steps"},     64'(o_step_count), 64'd0);
    check({tag, "_episodes"},  64'(o_episode_count), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Idle without enable: nothing happens.
    repeat (3) begin
      @(negedge clk);
      check("idle_no_env_reset", 64'(o_env_reset), 64'd0);
    end

    // Episode 1: env ends the episode at step 3.
    start_episode(32'd5, 32'd7);
    do_step(2'd2, 32'd6,  32'd8,  32'd1, 1'b0, 1'b0);
    do_step(2'd1, 32'd9,  32'd10, 32'd2, 1'b0, 1'b0);
    do_step(2'd3, 32'd11, 32'd12, 32'd5, 1'b1, 1'b0);

    // Back in IDLE: no new episode without enable, tuple outputs held.
    repeat (4) begin
      @(negedge clk);
      check("post_done_no_env_reset", 64'(o_env_reset), 64'd0);
    end
    check("done_held", 64'(o_done), 64'd1);

    // Episode 2: env never done, truncated at MAX steps; spurious inputs in step 2.
    start_episode(32'd1, 32'd2);
    do_step(2'd0, 32'd3, 32'd4, 32'd10, 1'b0, 1'b0);
    do_step(2'd1, 32'd5, 32'd6, 32'd20, 1'b0, 1'b1);
    do_step(2'd2, 32'd7, 32'd8, 32'd30, 1'b0, 1'b0);
    do_step(2'd3, 32'd9, 32'd9, 32'd40, 1'b0, 1'b0);

    // Episode 3: reset asserted while waiting for the environment.
    start_episode(32'd3, 32'd4);
    do_act(2'd1, 1'b0);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    step_m = 0; ep_m = 0;
    @(negedge clk); rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("post_reset_no_valid", 64'(o_valid), 64'd0);
    end

    // Full new handshake after reset.
    start_episode(32'd20, 32'd21);
    do_step(2'd2, 32'd22, 32'd23, 32'd7, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    check("tuple_sb_empty", 64'(tuple_q.size()), 64'd0);
    check("obs_sb_empty",   64'(obs_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_transition_collector

// File: doc/transition_collector.md
TRANSITION_COLLECTOR -- requirements
Module: transition_collector

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of state/reward words.
REQ-002 SHALL have parameter ACTION_WIDTH, default 2, width of action code.
REQ-003 SHALL have parameter MAX_EPISODE_STEPS, default 200, step limit forcing episode truncation.
REQ-004 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_enable  input  1  permits starting a new episode.
REQ-007 SHALL have ports i_env_valid (input 1), i_env_state_0/1 (input DATA_WIDTH each), i_env_reward (input DATA_WIDTH), i_env_done (input 1): environment observation.
REQ-008 SHALL have ports o_env_reset (output 1) and o_env_action_valid (output 1), both one-cycle pulses, plus o_env_action (output ACTION_WIDTH): environment commands.
REQ-009 SHALL have ports o_obs_valid (output 1, one-cycle pulse) and o_obs_state_0/1 (output DATA_WIDTH each): state presented to agent.
REQ-010 SHALL have ports i_act_valid (input 1) and i_action (input ACTION_WIDTH): agent's chosen action.
REQ-011 SHALL have ports o_valid (output 1), o_current_state_0/1, o_reward, o_next_state_0/1 (output DATA_WIDTH each), o_action (output ACTION_WIDTH), o_done (output 1): transition tuple to replay memory.
REQ-012 SHALL have ports o_step_count and o_episode_count (output 16 each): step in current episode, completed episodes.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT_INIT, OBSERVE, WAIT_ACT, WAIT_ENV, EMIT.
REQ-014 IDLE: when i_enable=1, pulse o_env_reset for 1 cycle, go WAIT_INIT; otherwise stay.
REQ-015 WAIT_INIT: on i_env_valid, latch i_env_state_0/1 as current state, ignore reward/done, go OBSERVE.
REQ-016 OBSERVE: pulse o_obs_valid for exactly 1 cycle with o_obs_state_0/1 = current state, go WAIT_ACT.
REQ-017 WAIT_ACT: on i_act_valid, latch i_action, drive o_env_action with it, pulse o_env_action_valid for 1 cycle, go WAIT_ENV.
REQ-018 WAIT_ENV: on i_env_valid, latch next state, reward, done; increment step count; go EMIT.
REQ-019 Truncation: if the incremented step count equals MAX_EPISODE_STEPS, latched done SHALL be forced to 1.
REQ-020 EMIT: pulse o_valid for exactly 1 cycle with the latched tuple (current, action, reward, next, done).
REQ-021 EMIT with done=0: current state <= next state, go OBSERVE.
REQ-022 EMIT with done=1: step count <= 0, episode count +1 (wraps at 2^16), go IDLE.
REQ-023 i_act_valid outside WAIT_ACT and i_env_valid outside WAIT_INIT/WAIT_ENV SHALL be ignored without side effect.
REQ-024 Tuple outputs SHALL hold last emitted values between o_valid pulses; o_obs_state_0/1 SHALL hold the current state continuously.
REQ-025 Minimum latency: i_env_valid in WAIT_ENV at cycle N -> o_valid at N+1 -> o_obs_valid at N+2 (done=0).
REQ-026 i_enable low mid-episode SHALL NOT abort the episode; it is sampled only in IDLE.

Reset
REQ-027 Asserting rst_n low SHALL immediately force state IDLE and all outputs, counters and latched registers to 0, including mid-episode.
REQ-028 After reset release the first action SHALL be o_env_reset, issued one cycle after i_enable is seen high.

Structure
REQ-029 FSM state encoding and default parameter values SHALL reside in a shared package used by the DQN blocks.
REQ-030 The block SHALL be a single module with no sub-modules; o_valid and tuple outputs connect directly to replay memory i_valid/tuple inputs.

Verification
REQ-031 Reset, i_enable=1 -> o_env_reset pulse; init state (5,7) -> o_obs_valid with state (5,7).
REQ-032 Action 2, env returns (6,8), reward 1, done 0 -> o_valid tuple (5,7,2,1,6,8,0), then o_obs_valid with (6,8), o_step_count=1.
REQ-033 Env returns done=1 at step 3 -> o_done=1, o_episode_count=1, o_step_count=0, FSM in IDLE, next o_env_reset only when i_enable=1.
REQ-034 MAX_EPISODE_STEPS=4, env never done -> 4th tuple has o_done=1, new episode begins.
REQ-035 Spurious i_act_valid in WAIT_ENV and i_env_valid in WAIT_ACT -> no outputs pulse, latched values unchanged.
REQ-036 rst_n low during WAIT_ENV -> all outputs 0 immediately; after release, no o_valid until a full new handshake completes.
